fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencing controller for the instruction-fetch stage. It produces the IFU's stall, redirect
//  (dnpc_flag/dnpc) and ready controls, and the IF/ID and ID/EX flush strobes.
//  Redirect, hazard and halt requests from later stages are arbitrated into one fetch decision
//  per cycle. Sits between decode/EX/WB hazard sources and the IFU's PC register.
// PARAMETERS
//  BOOT_CYCLES  4      cycles after reset release with fetch held (IROM warm-up); 0 = none
//  MAX_STALL    16     consecutive load-use stall cycles before stall_timeout sets
//  XLEN         32     address width
// PORTS
//  clock          in   1     system clock, all state on posedge
//  reset          in   1     synchronous, active-high
//  load_use_haz   in   1     decode load-use hazard: hold PC and IF/ID, bubble ID/EX
//  ex_redirect    in   1     EX resolved taken branch/jump
//  ex_target      in   XLEN  EX redirect target
//  halt_req       in   1     ebreak retired in WB
//  resume         in   1     leave HALT (debug/testbench)
//  ifu_stall      out  1     to IFU stall
//  ifu_dnpc_flag  out  1     to IFU dnpc_flag
//  ifu_dnpc       out  XLEN  to IFU dnpc
//  ifu_ready      out  1     to IFU ready; 0 freezes PC
//  flush_ifid     out  1     clear IF/ID register this cycle
//  flush_idex     out  1     insert bubble into ID/EX this cycle
//  halted         out  1     FSM in HALT
//  stall_timeout  out  1     sticky error flag
//  perf_stall_cnt out  32    stall cycles (perf option)
//  perf_redir_cnt out  32    redirects taken (perf option)
// BEHAVIOUR
//  - FSM states BOOT, RUN, HALT; reset -> BOOT, boot counter = 0.
//  - Reset values: ifu_ready=0, ifu_stall=0, ifu_dnpc_flag=0, ifu_dnpc=0, flush_*=1 (BOOT),
//    halted=0, stall_timeout=0, perf counters=0.
//  - Reset asserted in any state, including mid-redirect or mid-HALT, returns to BOOT next edge.
//  - BOOT: ifu_ready=0, flush_ifid=flush_idex=1. Counter increments each cycle.
//    Go to RUN on the edge where counter==BOOT_CYCLES-1; BOOT_CYCLES=0 goes to RUN on the first
//    edge after reset. Hazard and redirect inputs are ignored.
//  - RUN: ifu_ready=1. Controls are combinational from inputs (same-cycle, zero latency).
//    Priority, highest first:
//      halt_req: ifu_ready=0, flush both, next=HALT.
//      ex_redirect: ifu_dnpc_flag=1, ifu_dnpc=ex_target, ifu_stall=0, flush_ifid=flush_idex=1.
//        Redirect overrides a simultaneous load_use_haz, because the hazard instruction is
//        flushed.
//      load_use_haz: ifu_stall=1, flush_idex=1, flush_ifid=0.
//      none: all controls 0 except ifu_ready.
//  - ifu_dnpc = ex_target whenever ex_redirect=1, else 0 (no X propagation).
//  - Stall counter: counts consecutive RUN cycles with load_use_haz as the winning request;
//    cleared otherwise. Saturates at MAX_STALL.
//    On reaching MAX_STALL, stall_timeout sets and stays 1 until reset. Fetch behaviour does
//    not change.
//  - HALT: ifu_ready=0, halted=1, flush both held 1. resume=1 -> RUN next edge, with ifu_ready=1
//    from that cycle; halt_req in HALT is ignored.
//  - resume outside HALT has no effect.
// CONFIGURATION
//  - FETCH_CTRL_PERF_EN defined: perf_stall_cnt increments on each RUN cycle with ifu_stall=1.
//    perf_redir_cnt increments on each RUN cycle with ifu_dnpc_flag=1. Both saturate at
//    32'hFFFF_FFFF and clear on reset.
//  - FETCH_CTRL_PERF_EN undefined: no counter flops; both ports are driven constant 0.
// STRUCTURE
//  - fetch_ctrl_pkg: fsm_state_t enum (BOOT, RUN, HALT), RESET_PC = 32'h0, default constants for
//    BOOT_CYCLES and MAX_STALL.
//  - One sub-module, fetch_ctrl_sat_cnt: parameterised-width saturating counter (inc, clr).
//    Used by the boot counter, the stall counter and both perf counters.
// TESTING
//  - Reset then idle, BOOT_CYCLES=4 -> ifu_ready=0 and flush_*=1 for cycles 0..3; ifu_ready=1
//    from cycle 4.
//  - RUN, ex_redirect=1 with ex_target=32'h0000_0100 for 1 cycle -> same cycle ifu_dnpc_flag=1,
//    ifu_dnpc=0x100, flush_ifid=flush_idex=1.
//  - RUN, load_use_haz=1 and ex_redirect=1 together -> ifu_stall=0, ifu_dnpc_flag=1; perf redirect
//    count +1, stall count +0.
//  - RUN, load_use_haz held 16 cycles -> ifu_stall=1, flush_idex=1 every cycle; stall_timeout=1
//    after the 16th cycle and stays 1 after load_use_haz drops.
//  - halt_req=1 -> halted=1 next cycle, ifu_ready=0. Apply resume=1 -> halted=0 and ifu_ready=1
//    the following cycle.
//  - reset asserted during HALT and during a redirect cycle -> BOOT next edge, all outputs at
//    reset values, stall_timeout cleared.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and constants for the instruction-fetch sequencing controller.
//   fsm_state_t          : controller state (BOOT, RUN, HALT)
//   RESET_PC             : value driven on ifu_dnpc when no redirect is active
//   DEFAULT_BOOT_CYCLES  : default IROM warm-up length after reset release
//   DEFAULT_MAX_STALL    : default consecutive load-use stall limit
//   cnt_width()          : bits needed for a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_state_t;

  localparam logic [31:0] RESET_PC            = 32'h0000_0000;
  localparam int          DEFAULT_BOOT_CYCLES = 4;
  localparam int          DEFAULT_MAX_STALL   = 16;

  // Minimum of one bit so zero/one-valued limits still yield a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the hazard/redirect request inputs and the IFU/pipeline control
// outputs of fetch_ctrl.
//   master : the controller side (fetch_ctrl); receives requests, drives controls
//   slave  : the environment side (hazard sources, IFU, pipeline registers)
// Signals:
//   load_use_haz, ex_redirect, ex_target[XLEN], halt_req, resume  (requests)
//   ifu_stall, ifu_dnpc_flag, ifu_dnpc[XLEN], ifu_ready           (IFU controls)
//   flush_ifid, flush_idex                                        (pipeline flush)
//   halted, stall_timeout, perf_stall_cnt[32], perf_redir_cnt[32] (status)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);

  logic            load_use_haz;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            halt_req;
  logic            resume;

  logic            ifu_stall;
  logic            ifu_dnpc_flag;
  logic [XLEN-1:0] ifu_dnpc;
  logic            ifu_ready;
  logic            flush_ifid;
  logic            flush_idex;
  logic            halted;
  logic            stall_timeout;
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_redir_cnt;

  modport master (
    input  load_use_haz, ex_redirect, ex_target, halt_req, resume,
    output ifu_stall, ifu_dnpc_flag, ifu_dnpc, ifu_ready,
    output flush_ifid, flush_idex, halted, stall_timeout,
    output perf_stall_cnt, perf_redir_cnt
  );

  modport slave (
    output load_use_haz, ex_redirect, ex_target, halt_req, resume,
    input  ifu_stall, ifu_dnpc_flag, ifu_dnpc, ifu_ready,
    input  flush_ifid, flush_idex, halted, stall_timeout,
    input  perf_stall_cnt, perf_redir_cnt
  );

endinterface

// File: rtl/fetch_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_sat_cnt
// Saturating up-counter with synchronous clear.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset (count -> 0)
//   inc    in   increment request; ignored once count equals MAX
//   clr    in   synchronous clear, wins over inc
//   count  out  WIDTH-bit current value
// Parameters:
//   WIDTH  counter width
//   MAX    saturation value (default all ones)
// -----------------------------------------------------------------------------
module fetch_ctrl_sat_cnt #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequencing controller for the instruction-fetch stage. Arbitrates halt,
// EX redirect and load-use hazard requests into one fetch decision per cycle
// and drives the IFU stall/redirect/ready controls plus IF/ID and ID/EX flushes.
// Ports:
//   clock   in      system clock, all state on posedge
//   reset   in      synchronous, active-high; returns the FSM to BOOT
//   bus     master  fetch_ctrl_if (requests in, IFU/pipeline controls out)
// Parameters:
//   BOOT_CYCLES  cycles with fetch held after reset release (0 = none)
//   MAX_STALL    consecutive load-use stall cycles before stall_timeout sets
//   XLEN         address width (must match the interface XLEN)
// Configuration macro:
//   FETCH_CTRL_PERF_EN  when defined, builds the saturating stall and redirect
//                       performance counters; otherwise both ports read 0.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = DEFAULT_BOOT_CYCLES,
  parameter int MAX_STALL   = DEFAULT_MAX_STALL,
  parameter int XLEN        = 32
) (
  input  logic          clock,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam int BOOT_W  = cnt_width(BOOT_CYCLES);
  localparam int STALL_W = cnt_width(MAX_STALL);

  fsm_state_t         state;
  logic [BOOT_W-1:0]  boot_count;
  logic [STALL_W-1:0] stall_count;
  logic               stall_timeout_q;

  logic               in_boot;
  logic               boot_done;
  logic               stall_win;
  logic               stall_hit;

  logic               ifu_ready;
  logic               ifu_stall;
  logic               ifu_dnpc_flag;
  logic               flush_ifid;
  logic               flush_idex;

  // Arbitration qualifiers. The load-use stall only counts when neither a halt
  // nor a redirect outranks it; stall_hit marks the cycle that completes the
  // MAX_STALL-th consecutive stall so the sticky flag is visible right after it.
  always_comb begin
    in_boot   = (state == BOOT);
    boot_done = (BOOT_CYCLES == 0) || (int'(boot_count) == BOOT_CYCLES - 1);
    stall_win = (state == RUN) && !bus.halt_req && !bus.ex_redirect && bus.load_use_haz;
    stall_hit = stall_win && (int'(stall_count) >= MAX_STALL - 1);
  end

  // Boot warm-up counter: runs only while in BOOT, parked at zero elsewhere.
  fetch_ctrl_sat_cnt #(
    .WIDTH (BOOT_W),
    .MAX   (BOOT_W'(BOOT_CYCLES))
  ) u_boot_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (in_boot),
    .clr   (!in_boot),
    .count (boot_count)
  );

  // Consecutive load-use stall counter; any non-stall cycle breaks the run.
  fetch_ctrl_sat_cnt #(
    .WIDTH (STALL_W),
    .MAX   (STALL_W'(MAX_STALL))
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_win),
    .clr   (!stall_win),
    .count (stall_count)
  );

  // Controller FSM and the sticky stall-timeout flag. Only reset clears the
  // flag; fetch behaviour is unaffected by it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= BOOT;
      stall_timeout_q <= 1'b0;
    end else begin
      unique case (state)
        BOOT:    if (boot_done)    state <= RUN;
        RUN:     if (bus.halt_req) state <= HALT;
        HALT:    if (bus.resume)   state <= RUN;
        default: state <= BOOT;
      endcase
      if (stall_hit) begin
        stall_timeout_q <= 1'b1;
      end
    end
  end

  // Fetch controls. In RUN they follow the request inputs in the same cycle
  // with priority halt > redirect > load-use; BOOT and HALT hold fetch off and
  // keep both pipeline registers flushed.
  always_comb begin
    ifu_ready     = 1'b0;
    ifu_stall     = 1'b0;
    ifu_dnpc_flag = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    unique case (state)
      RUN: begin
        ifu_ready = 1'b1;
        if (bus.halt_req) begin
          ifu_ready  = 1'b0;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (bus.ex_redirect) begin
          // The hazard instruction is flushed, so a redirect supersedes it.
          ifu_dnpc_flag = 1'b1;
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
        end else if (bus.load_use_haz) begin
          ifu_stall  = 1'b1;
          flush_idex = 1'b1;
        end
      end
      BOOT, HALT: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      default: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    endcase
  end

  assign bus.ifu_ready     = ifu_ready;
  assign bus.ifu_stall     = ifu_stall;
  assign bus.ifu_dnpc_flag = ifu_dnpc_flag;
  assign bus.flush_ifid    = flush_ifid;
  assign bus.flush_idex    = flush_idex;
  assign bus.halted        = (state == HALT);
  assign bus.stall_timeout = stall_timeout_q;

  // Target is forced to a known value when no redirect is requested so an
  // undriven ex_target never leaks X into the PC mux.
  assign bus.ifu_dnpc = bus.ex_redirect ? bus.ex_target : XLEN'(RESET_PC);

`ifdef FETCH_CTRL_PERF_EN
  logic perf_stall_inc;
  logic perf_redir_inc;

  assign perf_stall_inc = (state == RUN) && ifu_stall;
  assign perf_redir_inc = (state == RUN) && ifu_dnpc_flag;

  // Free-running event counters, saturating at all ones.
  fetch_ctrl_sat_cnt #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_perf_stall (
    .clock (clock),
    .reset (reset),
    .inc   (perf_stall_inc),
    .clr   (1'b0),
    .count (bus.perf_stall_cnt)
  );

  fetch_ctrl_sat_cnt #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_perf_redir (
    .clock (clock),
    .reset (reset),
    .inc   (perf_redir_inc),
    .clr   (1'b0),
    .count (bus.perf_redir_cnt)
  );
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_redir_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed self-checking bench for fetch_ctrl (BOOT_CYCLES=4, MAX_STALL=16).
// Control outputs are packed as {ready, stall, dnpc_flag, flush_ifid,
// flush_idex, halted, stall_timeout} and compared against hand-derived vectors.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected control vectors {R,S,F,I,X,H,T}
  localparam logic [6:0] C_BOOT      = 7'b0001100;
  localparam logic [6:0] C_IDLE      = 7'b1000000;
  localparam logic [6:0] C_IDLE_TO   = 7'b1000001;
  localparam logic [6:0] C_REDIR     = 7'b1011100;
  localparam logic [6:0] C_STALL     = 7'b1100100;
  localparam logic [6:0] C_HALTREQ_T = 7'b0001101;
  localparam logic [6:0] C_HALT_T    = 7'b0001111;
  localparam logic [6:0] C_HALT      = 7'b0001110;

  logic        clock;
  logic        reset;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_redir = 32'd0;

  fetch_ctrl_if #(.XLEN(32)) bus ();

  fetch_ctrl #(
    .BOOT_CYCLES (4),
    .MAX_STALL   (16),
    .XLEN        (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] ctl();
    return {bus.ifu_ready, bus.ifu_stall, bus.ifu_dnpc_flag, bus.flush_ifid,
            bus.flush_idex, bus.halted, bus.stall_timeout};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.load_use_haz = 1'b0;
    bus.ex_redirect  = 1'b0;
    bus.ex_target    = 32'h0;
    bus.halt_req     = 1'b0;
    bus.resume       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    exp_stall = 32'd0;
    exp_redir = 32'd0;
    sample();
    total_cnt++;
    if (ctl() !== C_BOOT) $display("[TB] FAIL reset_ctl got %b want %b", ctl(), C_BOOT);
    else pass_cnt++;
    total_cnt++;
    if (bus.ifu_dnpc !== 32'h0) $display("[TB] FAIL reset_dnpc got %h want %h", bus.ifu_dnpc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({bus.perf_stall_cnt, bus.perf_redir_cnt} !== 64'd0)
      $display("[TB] FAIL reset_perf got %h/%h want 0/0", bus.perf_stall_cnt, bus.perf_redir_cnt);
    else pass_cnt++;
  endtask

  task automatic test_boot();
    // Currently in boot cycle 0; cycles 0..3 hold fetch, cycle 4 runs.
    for (int c = 0; c < 4; c++) begin
      if (c != 0) sample();
      total_cnt++;
      if (ctl() !== C_BOOT) $display("[TB] FAIL boot_c%0d got %b want %b", c, ctl(), C_BOOT);
      else pass_cnt++;
      next_cycle();
    end
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE) $display("[TB] FAIL boot_exit got %b want %b", ctl(), C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    next_cycle();
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h0000_0100;
    sample();
    total_cnt++;
    if (ctl() !== C_REDIR) $display("[TB] FAIL redir_ctl got %b want %b", ctl(), C_REDIR);
    else pass_cnt++;
    total_cnt++;
    if (bus.ifu_dnpc !== 32'h0000_0100) $display("[TB] FAIL redir_dnpc got %h want %h", bus.ifu_dnpc, 32'h100);
    else pass_cnt++;
    next_cycle();
    exp_redir = exp_redir + 1;
    bus.ex_redirect = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE) $display("[TB] FAIL redir_after got %b want %b", ctl(), C_IDLE);
    else pass_cnt++;
    total_cnt++;
    if (bus.ifu_dnpc !== 32'h0) $display("[TB] FAIL redir_dnpc_idle got %h want %h", bus.ifu_dnpc, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_redirect_over_hazard();
    next_cycle();
    bus.load_use_haz = 1'b1;
    bus.ex_redirect  = 1'b1;
    bus.ex_target    = 32'h0000_0ABC;
    sample();
    total_cnt++;
    if (ctl() !== C_REDIR) $display("[TB] FAIL prio_ctl got %b want %b", ctl(), C_REDIR);
    else pass_cnt++;
    total_cnt++;
    if (bus.ifu_dnpc !== 32'h0000_0ABC) $display("[TB] FAIL prio_dnpc got %h want %h", bus.ifu_dnpc, 32'hABC);
    else pass_cnt++;
    next_cycle();
    exp_redir = exp_redir + 1;
    clear_inputs();
    sample();
    total_cnt++;
    if (bus.perf_redir_cnt !== (PERF ? exp_redir : 32'd0))
      $display("[TB] FAIL prio_perf_redir got %0d want %0d", bus.perf_redir_cnt, PERF ? exp_redir : 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (bus.perf_stall_cnt !== (PERF ? exp_stall : 32'd0))
      $display("[TB] FAIL prio_perf_stall got %0d want %0d", bus.perf_stall_cnt, PERF ? exp_stall : 32'd0);
    else pass_cnt++;
  endtask

  task automatic test_stall_timeout();
    next_cycle();
    bus.load_use_haz = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      sample();
      total_cnt++;
      if (ctl() !== C_STALL) $display("[TB] FAIL stall_c%0d got %b want %b", c, ctl(), C_STALL);
      else pass_cnt++;
      next_cycle();
    end
    exp_stall = exp_stall + 16;
    bus.load_use_haz = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE_TO) $display("[TB] FAIL timeout_set got %b want %b", ctl(), C_IDLE_TO);
    else pass_cnt++;
    total_cnt++;
    if (bus.perf_stall_cnt !== (PERF ? exp_stall : 32'd0))
      $display("[TB] FAIL stall_perf got %0d want %0d", bus.perf_stall_cnt, PERF ? exp_stall : 32'd0);
    else pass_cnt++;
    next_cycle();
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE_TO) $display("[TB] FAIL timeout_sticky got %b want %b", ctl(), C_IDLE_TO);
    else pass_cnt++;
  endtask

  task automatic test_halt_resume();
    next_cycle();
    bus.halt_req = 1'b1;
    sample();
    total_cnt++;
    if (ctl() !== C_HALTREQ_T) $display("[TB] FAIL halt_req got %b want %b", ctl(), C_HALTREQ_T);
    else pass_cnt++;
    // halt_req stays high while halted; it must be ignored there.
    next_cycle();
    sample();
    total_cnt++;
    if (ctl() !== C_HALT_T) $display("[TB] FAIL halt_state got %b want %b", ctl(), C_HALT_T);
    else pass_cnt++;
    next_cycle();
    bus.halt_req = 1'b0;
    bus.resume   = 1'b1;
    sample();
    total_cnt++;
    if (ctl() !== C_HALT_T) $display("[TB] FAIL halt_resume_cyc got %b want %b", ctl(), C_HALT_T);
    else pass_cnt++;
    next_cycle();
    bus.resume = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE_TO) $display("[TB] FAIL resumed got %b want %b", ctl(), C_IDLE_TO);
    else pass_cnt++;
  endtask

  task automatic test_resume_outside_halt();
    next_cycle();
    bus.resume = 1'b1;
    sample();
    next_cycle();
    bus.resume = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE_TO) $display("[TB] FAIL resume_in_run got %b want %b", ctl(), C_IDLE_TO);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_halt();
    next_cycle();
    bus.halt_req = 1'b1;
    next_cycle();
    bus.halt_req = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_HALT_T) $display("[TB] FAIL rst_halt_pre got %b want %b", ctl(), C_HALT_T);
    else pass_cnt++;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    exp_stall = 32'd0;
    exp_redir = 32'd0;
    sample();
    total_cnt++;
    if (ctl() !== C_BOOT) $display("[TB] FAIL rst_halt_ctl got %b want %b", ctl(), C_BOOT);
    else pass_cnt++;
    total_cnt++;
    if ({bus.perf_stall_cnt, bus.perf_redir_cnt} !== 64'd0)
      $display("[TB] FAIL rst_halt_perf got %h/%h want 0/0", bus.perf_stall_cnt, bus.perf_redir_cnt);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) next_cycle();
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE) $display("[TB] FAIL rst_halt_reboot got %b want %b", ctl(), C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_redirect();
    next_cycle();
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h0000_0200;
    reset           = 1'b1;
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    sample();
    total_cnt++;
    if (ctl() !== C_BOOT) $display("[TB] FAIL rst_redir_ctl got %b want %b", ctl(), C_BOOT);
    else pass_cnt++;
    total_cnt++;
    if (bus.ifu_dnpc !== 32'h0) $display("[TB] FAIL rst_redir_dnpc got %h want %h", bus.ifu_dnpc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.perf_redir_cnt !== 32'd0) $display("[TB] FAIL rst_redir_perf got %0d want 0", bus.perf_redir_cnt);
    else pass_cnt++;
    // A halt request during boot is ignored.
    next_cycle();
    bus.halt_req = 1'b1;
    sample();
    total_cnt++;
    if (ctl() !== C_BOOT) $display("[TB] FAIL boot_ignore_halt got %b want %b", ctl(), C_BOOT);
    else pass_cnt++;
    next_cycle();
    bus.halt_req = 1'b0;
    sample();
    total_cnt++;
    if (ctl() !== C_BOOT) $display("[TB] FAIL boot_no_halt got %b want %b", ctl(), C_BOOT);
    else pass_cnt++;
    // Reaching cycle 4 confirms boot still completes on time.
    next_cycle();
    next_cycle();
    sample();
    total_cnt++;
    if (ctl() !== C_IDLE) $display("[TB] FAIL rst_redir_reboot got %b want %b", ctl(), C_IDLE);
    else pass_cnt++;
    total_cnt++;
    if (ctl() === C_HALT) $display("[TB] FAIL boot_halt_leak got %b want %b", ctl(), C_IDLE);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    $display("[TB] fetch_ctrl directed test start (perf=%0d)", PERF);
    test_reset();
    test_boot();
    test_redirect();
    test_redirect_over_hazard();
    test_stall_timeout();
    test_halt_resume();
    test_resume_outside_halt();
    test_reset_in_halt();
    test_reset_in_redirect();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
